// File: rtl/sap_cpu_core.sv
// Parametrised SAP accumulator CPU core: variable-length micro-step sequencer,
// clock-enable stepping, host program port. Optional CAL/RET via SAP_CALL_RET_EN.
module sap_cpu_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step_en,
    input  logic              run,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_dbg,
    output logic [2:0]        step_dbg
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_OUT = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_STA = 4'h5;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_JC  = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;
`ifdef SAP_CALL_RET_EN
    localparam logic [3:0] OP_CAL = 4'hA;
    localparam logic [3:0] OP_RET = 4'hB;
`endif

    step_t             step_q;
    step_t             step_d;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic              c_flag;
    logic              z_flag;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] ram_rd;
    logic              advance;
    logic [DATA_W:0]   alu_res;

    logic ld_mar_pc, ld_ir, ld_mar_op, ld_a_ram, ld_b_ram, ld_a_imm;
    logic alu_en, alu_sub, do_out, ld_pc_op, ram_we_cpu, do_hlt;
`ifdef SAP_CALL_RET_EN
    logic [ADDR_W-1:0] rr;
    logic              ld_rr;
    logic              ld_pc_rr;
`endif

    // Carry out of the add is the top bit of the widened sum.
    function automatic logic [DATA_W:0] alu_add_f(input logic [DATA_W-1:0] x,
                                                  input logic [DATA_W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Carry on subtract means "no borrow": set when x >= y.
    function automatic logic [DATA_W:0] alu_sub_f(input logic [DATA_W-1:0] x,
                                                  input logic [DATA_W-1:0] y);
        logic [DATA_W-1:0] diff;
        diff = x - y;
        return {(x >= y), diff};
    endfunction

    assign opcode   = ir[DATA_W-1 -: 4];
    assign operand  = ir[ADDR_W-1:0];
    assign ram_rd   = mem[mar];
    assign advance  = run && step_en && !halted;
    assign alu_res  = alu_sub ? alu_sub_f(a_reg, b_reg) : alu_add_f(a_reg, b_reg);
    assign pc_dbg   = pc;
    assign step_dbg = step_q;

    always_comb begin
        step_d     = T0;
        ld_mar_pc  = 1'b0;
        ld_ir      = 1'b0;
        ld_mar_op  = 1'b0;
        ld_a_ram   = 1'b0;
        ld_b_ram   = 1'b0;
        ld_a_imm   = 1'b0;
        alu_en     = 1'b0;
        alu_sub    = 1'b0;
        do_out     = 1'b0;
        ld_pc_op   = 1'b0;
        ram_we_cpu = 1'b0;
        do_hlt     = 1'b0;
`ifdef SAP_CALL_RET_EN
        ld_rr      = 1'b0;
        ld_pc_rr   = 1'b0;
`endif
        case (step_q)
            T0: begin
                ld_mar_pc = 1'b1;
                step_d    = T1;
            end
            T1: begin
                ld_ir  = 1'b1;
                step_d = T2;
            end
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ld_mar_op = 1'b1;
                        step_d    = T3;
                    end
                    OP_OUT: do_out   = 1'b1;
                    OP_JMP: ld_pc_op = 1'b1;
                    OP_LDI: ld_a_imm = 1'b1;
                    OP_JC:  ld_pc_op = c_flag;
                    OP_JZ:  ld_pc_op = z_flag;
                    OP_HLT: do_hlt   = 1'b1;
`ifdef SAP_CALL_RET_EN
                    OP_CAL: begin
                        ld_pc_op = 1'b1;
                        ld_rr    = 1'b1;
                    end
                    OP_RET: ld_pc_rr = 1'b1;
`endif
                    default: ;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: ld_a_ram = 1'b1;
                    OP_ADD, OP_SUB: begin
                        ld_b_ram = 1'b1;
                        step_d   = T4;
                    end
                    OP_STA: ram_we_cpu = 1'b1;
                    default: ;
                endcase
            end
            T4: begin
                alu_en  = (opcode == OP_ADD) || (opcode == OP_SUB);
                alu_sub = (opcode == OP_SUB);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q    <= T0;
            pc        <= '0;
            mar       <= '0;
            ir        <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            c_flag    <= 1'b0;
            z_flag    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (advance) begin
                step_q <= step_d;
                if (ld_mar_pc) mar <= pc;
                if (ld_mar_op) mar <= operand;
                if (ld_ir) begin
                    ir <= ram_rd;
                    pc <= pc + ADDR_W'(1);
                end
                if (ld_pc_op) pc <= operand;
`ifdef SAP_CALL_RET_EN
                if (ld_pc_rr) pc <= rr;
`endif
                if (ld_a_ram) a_reg <= ram_rd;
                if (ld_a_imm) a_reg <= {{(DATA_W-ADDR_W){1'b0}}, operand};
                if (ld_b_ram) b_reg <= ram_rd;
                if (alu_en) begin
                    {c_flag, a_reg} <= alu_res;
                    z_flag          <= (alu_res[DATA_W-1:0] == '0);
                end
                if (do_out) begin
                    out_data  <= a_reg;
                    out_valid <= 1'b1;
                end
                if (do_hlt) halted <= 1'b1;
            end
        end
    end

`ifdef SAP_CALL_RET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= '0;
        end else if (advance && ld_rr) begin
            rr <= pc;
        end
    end
`endif

    // Core and host never write in the same cycle: the core only advances with run=1.
    always_ff @(posedge clk) begin
        if (advance && ram_we_cpu) begin
            mem[mar] <= a_reg;
        end else if (!run && prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

endmodule

// File: tb/tb_sap_cpu_core.sv
// Scoreboard bench for sap_cpu_core: OUT values are queued at stimulus time and
// popped by a monitor on out_valid; register state is checked directly.
module tb_sap_cpu_core;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst_n;
    logic              step_en;
    logic              run;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              halted;
    logic [ADDR_W-1:0] pc_dbg;
    logic [2:0]        step_dbg;

    sap_cpu_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_en   (step_en),
        .run       (run),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .halted    (halted),
        .pc_dbg    (pc_dbg),
        .step_dbg  (step_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [DATA_W-1:0] sb[$];
    bit gap_chk   = 1'b0;
    bit have_prev = 1'b0;
    int last_cyc  = 0;
    int exp_gap   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest queued value.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                chk("out_unexpected", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                chk("out_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
            end
            if (gap_chk && have_prev) chk("out_gap", cyc - last_cyc, exp_gap);
            have_prev = 1'b1;
            last_cyc  = cyc;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        run     = 1'b0;
        step_en = 1'b0;
        prog_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic prog_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        @(negedge clk);
        run       = 1'b0;
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic pulse_step(input logic [2:0] exp_step, input string name);
        logic [2:0]        s;
        logic [ADDR_W-1:0] p;
        @(negedge clk);
        step_en = 1'b1;
        @(negedge clk);
        step_en = 1'b0;
        chk(name, step_dbg, exp_step);
        s = step_dbg;
        p = pc_dbg;
        repeat (3) @(negedge clk);
        chk("idle_step_hold", step_dbg, s);
        chk("idle_pc_hold", pc_dbg, p);
    endtask

    initial begin
        int k;
        int sub_cnt;
        logic [DATA_W-1:0] v;

        rst_n = 1'b1; step_en = 1'b0; run = 1'b0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;

        // Reset state
        do_reset();
        chk("rst_pc", pc_dbg, 0);
        chk("rst_step", step_dbg, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_halted", halted, 0);

        // Doubling loop: LDA 5, OUT, ADD 5, STA 5, JMP 1, data 1
        prog_write(0, 8'h15); prog_write(1, 8'h30); prog_write(2, 8'h25);
        prog_write(3, 8'h55); prog_write(4, 8'h41); prog_write(5, 8'h01);
        do_reset();
        v = 8'd1;
        for (int i = 0; i < 8; i++) begin
            sb.push_back(v);
            v = v << 1;
        end
        sb.push_back(8'd0);
        have_prev = 1'b0; gap_chk = 1'b1; exp_gap = 15;
        @(negedge clk);
        run = 1'b1; step_en = 1'b1;
        k = 0;
        while (sb.size() != 0 && k < 400) begin @(negedge clk); k++; end
        chk("dbl_done", sb.size(), 0);
        chk("dbl_c", dut.c_flag, 1);
        chk("dbl_z", dut.z_flag, 1);
        run = 1'b0; step_en = 1'b0; gap_chk = 1'b0;
        sb.delete();
        @(negedge clk);

        // Countdown: LDI 3, SUB 14, JZ 4, JMP 1, HLT; RAM[14]=1
        prog_write(0, 8'h73); prog_write(1, 8'h6E); prog_write(2, 8'h94);
        prog_write(3, 8'h41); prog_write(4, 8'hF0); prog_write(14, 8'h01);
        do_reset();
        @(negedge clk);
        run = 1'b1; step_en = 1'b1;
        sub_cnt = 0; k = 0;
        while (!halted && k < 300) begin
            @(negedge clk);
            if (step_dbg == 3'd4 && !halted) sub_cnt++;
            k++;
        end
        chk("cd_halted", halted, 1);
        chk("cd_sub_count", sub_cnt, 3);
        chk("cd_a", dut.a_reg, 0);
        chk("cd_z", dut.z_flag, 1);
        chk("cd_c", dut.c_flag, 1);
        chk("cd_pc", pc_dbg, 5);
        repeat (20) @(negedge clk);
        chk("cd_halt_hold", halted, 1);
        chk("cd_pc_hold", pc_dbg, 5);
        run = 1'b0; step_en = 1'b0;

        // Single stepping: LDA 2, OUT, data 0x5A
        prog_write(0, 8'h12); prog_write(1, 8'h30); prog_write(2, 8'h5A);
        do_reset();
        @(negedge clk);
        run = 1'b1;
        pulse_step(3'd1, "stp_1");
        pulse_step(3'd2, "stp_2");
        chk("stp_pc", pc_dbg, 1);
        pulse_step(3'd3, "stp_3");
        pulse_step(3'd0, "stp_0");
        chk("stp_a", dut.a_reg, 8'h5A);
        sb.push_back(8'h5A);
        pulse_step(3'd1, "stp_out1");
        pulse_step(3'd2, "stp_out2");
        pulse_step(3'd0, "stp_out0");
        chk("stp_out_done", sb.size(), 0);
        sb.delete();
        run = 1'b0;

        // Program port gating
        prog_write(3, 8'h11);
        @(negedge clk);
        run = 1'b1; step_en = 1'b0;
        prog_we = 1'b1; prog_addr = 3; prog_data = 8'hAA;
        @(negedge clk);
        prog_we = 1'b0;
        chk("pp_run_ignored", dut.mem[3], 8'h11);
        prog_write(3, 8'hAA);
        chk("pp_write", dut.mem[3], 8'hAA);

        // Reset in the middle of ADD at T3
        prog_write(0, 8'h14); prog_write(1, 8'h24); prog_write(2, 8'h00);
        prog_write(4, 8'h10);
        do_reset();
        @(negedge clk);
        run = 1'b1; step_en = 1'b1;
        k = 0;
        while (!(pc_dbg == 2 && step_dbg == 3) && k < 50) begin @(negedge clk); k++; end
        chk("mid_reached", (pc_dbg == 2 && step_dbg == 3), 1);
        chk("mid_a", dut.a_reg, 8'h10);
        rst_n = 1'b0;
        #1;
        chk("mid_pc", pc_dbg, 0);
        chk("mid_step", step_dbg, 0);
        chk("mid_a_clr", dut.a_reg, 0);
        chk("mid_b_clr", dut.b_reg, 0);
        chk("mid_mar_ir", {dut.mar, dut.ir}, 0);
        chk("mid_flags", {dut.c_flag, dut.z_flag}, 0);
        chk("mid_outs", {out_data, out_valid, halted}, 0);
        chk("mid_ram4", dut.mem[4], 8'h10);
        chk("mid_ram1", dut.mem[1], 8'h24);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_refetch_ir", dut.ir, 8'h14);
        chk("mid_refetch_pc", pc_dbg, 1);
        run = 1'b0; step_en = 1'b0;

        // PC wrap over a RAM of NOPs
        for (int i = 0; i < 16; i++) prog_write(i[ADDR_W-1:0], 8'h00);
        do_reset();
        @(negedge clk);
        run = 1'b1; step_en = 1'b1;
        k = 0;
        while (pc_dbg != 15 && k < 100) begin @(negedge clk); k++; end
        chk("wrap_reach15", pc_dbg, 15);
        k = 0;
        while (pc_dbg == 15 && k < 10) begin @(negedge clk); k++; end
        chk("wrap_to0", pc_dbg, 0);
        run = 1'b0; step_en = 1'b0;

        // CAL 8 at address 2, RET at address 8
        prog_write(2, 8'hA8); prog_write(8, 8'hB0);
        do_reset();
        @(negedge clk);
        run = 1'b1; step_en = 1'b1;
`ifdef SAP_CALL_RET_EN
        k = 0;
        while (pc_dbg != 8 && k < 50) begin @(negedge clk); k++; end
        chk("cal_pc", pc_dbg, 8);
        chk("cal_rr", dut.rr, 3);
        k = 0;
        while (!(dut.ir == 8'hB0 && step_dbg == 0) && k < 50) begin @(negedge clk); k++; end
        chk("ret_pc", pc_dbg, 3);
`else
        k = 0;
        while (!(dut.ir == 8'hA8 && step_dbg == 0) && k < 50) begin @(negedge clk); k++; end
        chk("cal_as_nop_pc", pc_dbg, 3);
`endif
        run = 1'b0; step_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
